display_hex_mux: RTL
====================

# display_hex_mux

Two-digit multiplexed hexadecimal 7-segment display driver that reads the 8-bit count from the button counter and shows it on a common-anode display. It scans the two digits at a parameterised refresh rate and inserts one blanking cycle at each digit change to prevent ghosting. It captures the input value once per scan frame, so a value that changes mid-frame never produces a torn display. It sits between the counter output and the board's segment/anode pins.

## Interface

- REFRESH_DIV, default 1000: clk cycles each digit slot is held; legal range 2..65535.
- BLANK_LZ, default 1: 1 blanks the high digit when the high nibble is 0; 0 always shows it.

- clk  in  1  system clock; all state on rising edge.
- reset_i  in  1  reset; asynchronous, active-low (0 = reset).
- conta_i  in  8  value to display; sampled only at frame wrap.
- seg_o  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an_o  out  2  digit anodes, active-low; an_o[0] = low nibble, an_o[1] = high nibble.
- frame_o  out  1  one-cycle pulse marking a new frame and a fresh capture of conta_i.

## Operation

- State:
  - div_q: 16-bit slot counter, 0..REFRESH_DIV-1.
  - sel_q: digit select; 0 = low nibble, 1 = high nibble.
  - disp_q: 8-bit captured value.
- Slot counter:
  - div_q increments each cycle.
  - When div_q == REFRESH_DIV-1, it wraps to 0 and sel_q toggles.
- Frame wrap (div_q == REFRESH_DIV-1 while sel_q == 1):
  - Same edge: disp_q <= conta_i and frame_o <= 1.
  - frame_o is 0 on all other cycles.
- Output registers, computed each edge from the pre-edge state:
  - If div_q == 0: an_o <= 2'b11 and seg_o <= 7'b1111111 (blanking cycle).
  - Else, if sel_q == 1, BLANK_LZ == 1 and disp_q[7:4] == 0: an_o <= 2'b11 and seg_o <= 7'b1111111.
  - Else: an_o <= ~(2'b01 << sel_q); seg_o <= hex decode of the selected nibble.
- Hex decode (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Reset (asynchronous on reset_i falling; held while reset_i=0):
  - div_q=0, sel_q=0, disp_q=8'h00.
  - seg_o=7'b1111111, an_o=2'b11, frame_o=0.
- After reset, until the first frame wrap, disp_q=00 is shown: low digit "0"; high digit blank if BLANK_LZ=1, otherwise "0".

## Timing

- Outputs are fully registered. an_o/seg_o reflect the state one cycle earlier.
- Slot length is REFRESH_DIV cycles: 1 blanking cycle, then REFRESH_DIV-1 lit cycles.
- Frame period is 2·REFRESH_DIV cycles. frame_o pulses exactly once per frame.
- Capture-to-display latency:
  - conta_i is sampled on the frame_o edge.
  - The first lit cycle showing the new low digit appears 2 cycles after that edge (blank cycle first).
  - The new high digit appears REFRESH_DIV+2 cycles after that edge.
- conta_i changes at any time other than the frame-wrap edge have no effect until the next frame wrap.
- Reset mid-frame:
  - Outputs blank immediately, without waiting for a clock.
  - After release, the first rising edge increments div_q from 0 and the scan restarts at the low digit.
  - The first lit low digit appears 2 edges after release.
- With REFRESH_DIV=2, each slot is 1 blank cycle plus 1 lit cycle. This is legal and must not lock up.

## Test plan

All scenarios use REFRESH_DIV=4 (8-cycle frame) unless noted.

- Reset: hold reset_i=0 for 3 cycles with conta_i=8'h3A -> an_o=11, seg_o=1111111, frame_o=0 throughout; the first frame_o occurs 8 edges after release.
- Capture/decode: conta_i=8'h3A, run 2 frames -> after the second frame_o, low slot shows an_o=10, seg_o=0001000; high slot shows an_o=01, seg_o=0110000; each slot is preceded by exactly one an_o=11 cycle.
- Leading-zero: conta_i=8'h05 with BLANK_LZ=1 -> high slot an_o=11, seg_o=1111111; low slot seg_o=0010010. With BLANK_LZ=0 -> high slot an_o=01, seg_o=1000000.
- Tear-free: display 8'h12, change conta_i to 8'hFF 2 cycles after frame_o -> the rest of the frame still shows 1/2; after the next frame_o, both digits show seg_o=0001110.
- Frame cadence: run 10 frames -> frame_o is high exactly 1 cycle per 8 cycles, never 2 in a row; an_o never has both bits 0.
- Reset mid-frame: assert reset_i=0 asynchronously in the middle of the high slot -> an_o=11 and seg_o=1111111 before the next edge; disp_q reads 00, so after release the low slot shows 1000000 until the next frame wrap.

Source files
------------

// File: rtl/display_hex_mux.sv
// Two-digit multiplexed hex driver for a common-anode 7-segment display.
// The input is captured once per scan frame, and every digit change gets one blanking cycle.
module display_hex_mux #(
    parameter int REFRESH_DIV = 1000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input  logic       clk,
    input  logic       reset_i,
    input  logic [7:0] conta_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o,
    output logic       frame_o
);

    logic [15:0] r_div;
    logic        r_sel;
    logic [7:0]  r_disp;

    logic        w_wrap;
    logic        w_blank;
    logic [3:0]  w_nib;
    logic [6:0]  w_seg;

    assign w_wrap  = (r_div == 16'(REFRESH_DIV - 1));
    assign w_nib   = r_sel ? r_disp[7:4] : r_disp[3:0];
    // Blank on the first cycle of each slot, and on a leading-zero high digit.
    assign w_blank = (r_div == 16'd0) || (r_sel && BLANK_LZ && (r_disp[7:4] == 4'h0));

    always_comb begin
        w_seg = 7'b1111111;
        case (w_nib)
            4'h0: w_seg = 7'b1000000;
            4'h1: w_seg = 7'b1111001;
            4'h2: w_seg = 7'b0100100;
            4'h3: w_seg = 7'b0110000;
            4'h4: w_seg = 7'b0011001;
            4'h5: w_seg = 7'b0010010;
            4'h6: w_seg = 7'b0000010;
            4'h7: w_seg = 7'b1111000;
            4'h8: w_seg = 7'b0000000;
            4'h9: w_seg = 7'b0010000;
            4'hA: w_seg = 7'b0001000;
            4'hB: w_seg = 7'b0000011;
            4'hC: w_seg = 7'b1000110;
            4'hD: w_seg = 7'b0100001;
            4'hE: w_seg = 7'b0000110;
            4'hF: w_seg = 7'b0001110;
            default: w_seg = 7'b1111111;
        endcase
    end

    always_ff @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            r_div   <= 16'd0;
            r_sel   <= 1'b0;
            r_disp  <= 8'h00;
            seg_o   <= 7'b1111111;
            an_o    <= 2'b11;
            frame_o <= 1'b0;
        end else begin
            r_div   <= w_wrap ? 16'd0 : r_div + 16'd1;
            if (w_wrap)
                r_sel <= ~r_sel;
            // Capturing only at the frame wrap keeps both digits from one sample.
            if (w_wrap && r_sel)
                r_disp <= conta_i;
            frame_o <= w_wrap && r_sel;
            if (w_blank) begin
                an_o  <= 2'b11;
                seg_o <= 7'b1111111;
            end else begin
                an_o  <= r_sel ? 2'b01 : 2'b10;
                seg_o <= w_seg;
            end
        end
    end

endmodule
